// File: rtl/maxpool_l1_if.sv
// Pooling-engine handshake and conv-result memory bus.
// The master side is the pooling block; the slave side is the controller/memory.
interface maxpool_l1_if #(
    parameter int DATA_W = 20
);
    logic              start;
    logic              busy;
    logic              done;
    logic              crd;
    logic [11:0]       caddr_rd;
    logic [DATA_W-1:0] cdata_rd;
    logic              cwr;
    logic [11:0]       caddr_wr;
    logic [DATA_W-1:0] cdata_wr;
    logic [2:0]        csel;

    modport master (
        input  start, cdata_rd,
        output busy, done, crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel
    );

    modport slave (
        output start, cdata_rd,
        input  busy, done, crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel
    );
endinterface

// File: rtl/maxpool_l1.sv
// 2x2/stride-2 max pooling of a 64x64 layer-0 map into a 32x32 layer-1 map.
// Define MAXPOOL_DUAL_KERNEL_EN to also pool kernel 1 (L0K1 -> L1K1) before done.
module maxpool_l1 #(
    parameter int DATA_W = 20
) (
    input  logic          clk,
    input  logic          reset,
    maxpool_l1_if.master  bus
);
    typedef enum logic [2:0] {IDLE, READ, LAST, WRITE, DONE} state_t;

    localparam logic [2:0] SEL_NONE = 3'b000;
    localparam logic [2:0] SEL_L0K0 = 3'b001;
    localparam logic [2:0] SEL_L0K1 = 3'b010;
    localparam logic [2:0] SEL_L1K0 = 3'b011;
    localparam logic [2:0] SEL_L1K1 = 3'b100;

    state_t            state_reg, state_next;
    logic [4:0]        r_reg, r_next;
    logic [4:0]        c_reg, c_next;
    logic [1:0]        k_reg, k_next;
    logic              kern_reg, kern_next;
    logic [DATA_W-1:0] max_reg, word_max;
    logic              cap_vld_reg, cap_first_reg;

    logic              busy_reg, busy_next;
    logic              done_reg, done_next;
    logic              crd_reg, crd_next;
    logic [11:0]       caddr_rd_reg, caddr_rd_next;
    logic              cwr_reg, cwr_next;
    logic [11:0]       caddr_wr_reg, caddr_wr_next;
    logic [DATA_W-1:0] cdata_wr_reg, cdata_wr_next;
    logic [2:0]        csel_reg, csel_next;

    // Unsigned compare; strict so equal words keep the earlier value.
    assign word_max = (bus.cdata_rd > max_reg) ? bus.cdata_rd : max_reg;

    always_comb begin
        state_next = state_reg;
        r_next     = r_reg;
        c_next     = c_reg;
        k_next     = k_reg;
        kern_next  = kern_reg;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    state_next = READ;
                    r_next     = 5'd0;
                    c_next     = 5'd0;
                    k_next     = 2'd0;
                    kern_next  = 1'b0;
                end
            end
            READ: begin
                if (k_reg == 2'd3) begin
                    state_next = LAST;
                end else begin
                    k_next = k_reg + 2'd1;
                end
            end
            LAST: state_next = WRITE;
            WRITE: begin
                k_next = 2'd0;
                if (c_reg == 5'd31) begin
                    c_next = 5'd0;
                    if (r_reg == 5'd31) begin
                        r_next = 5'd0;
`ifdef MAXPOOL_DUAL_KERNEL_EN
                        if (!kern_reg) begin
                            kern_next  = 1'b1;
                            state_next = READ;
                        end else begin
                            state_next = DONE;
                        end
`else
                        state_next = DONE;
`endif
                    end else begin
                        r_next     = r_reg + 5'd1;
                        state_next = READ;
                    end
                end else begin
                    c_next     = c_reg + 5'd1;
                    state_next = READ;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are derived from the next state so they are registered yet
    // line up with the state they belong to.
    always_comb begin
        busy_next     = (state_next == READ) || (state_next == LAST) || (state_next == WRITE);
        done_next     = (state_next == DONE);
        crd_next      = (state_next == READ);
        cwr_next      = (state_next == WRITE);
        caddr_rd_next = caddr_rd_reg;
        caddr_wr_next = caddr_wr_reg;
        cdata_wr_next = cdata_wr_reg;
        csel_next     = SEL_NONE;
        if (crd_next) begin
            // A = r*128 + c*2; k selects the +1 column and +64 row offsets.
            caddr_rd_next = {r_next, k_next[1], c_next, k_next[0]};
            csel_next     = kern_next ? SEL_L0K1 : SEL_L0K0;
        end
        if (cwr_next) begin
            caddr_wr_next = {2'b00, r_reg, c_reg};
            cdata_wr_next = word_max;
            csel_next     = kern_next ? SEL_L1K1 : SEL_L1K0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            r_reg         <= 5'd0;
            c_reg         <= 5'd0;
            k_reg         <= 2'd0;
            kern_reg      <= 1'b0;
            max_reg       <= '0;
            cap_vld_reg   <= 1'b0;
            cap_first_reg <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            crd_reg       <= 1'b0;
            caddr_rd_reg  <= 12'd0;
            cwr_reg       <= 1'b0;
            caddr_wr_reg  <= 12'd0;
            cdata_wr_reg  <= '0;
            csel_reg      <= SEL_NONE;
        end else begin
            state_reg     <= state_next;
            r_reg         <= r_next;
            c_reg         <= c_next;
            k_reg         <= k_next;
            kern_reg      <= kern_next;
            // Read data trails crd by one cycle; track which word is arriving.
            cap_vld_reg   <= crd_reg;
            cap_first_reg <= crd_reg && (k_reg == 2'd0);
            if (cap_vld_reg) begin
                max_reg <= cap_first_reg ? bus.cdata_rd : word_max;
            end
            busy_reg      <= busy_next;
            done_reg      <= done_next;
            crd_reg       <= crd_next;
            caddr_rd_reg  <= caddr_rd_next;
            cwr_reg       <= cwr_next;
            caddr_wr_reg  <= caddr_wr_next;
            cdata_wr_reg  <= cdata_wr_next;
            csel_reg      <= csel_next;
        end
    end

    assign bus.busy     = busy_reg;
    assign bus.done     = done_reg;
    assign bus.crd      = crd_reg;
    assign bus.caddr_rd = caddr_rd_reg;
    assign bus.cwr      = cwr_reg;
    assign bus.caddr_wr = caddr_wr_reg;
    assign bus.cdata_wr = cdata_wr_reg;
    assign bus.csel     = csel_reg;
endmodule
